// File: rtl/mem_ext_loader.sv
// Host-side loader: byte command stream in, single-cycle IMEM/DMEM access pulses out, read-back bytes on tx.
// Optional status byte after every command is enabled by defining LOADER_ACK_EN.
module mem_ext_loader #(
    parameter int CNT_W     = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [31:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [31:0] wdata_ext_2,
    input  logic [31:0] rdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        err
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_CNT, ST_WDATA, ST_WRITE,
        ST_RD_REQ, ST_RD_CAP, ST_TX, ST_ACK
    } state_t;

    localparam logic [7:0] OP_CLR     = 8'h00;
    localparam logic [7:0] OP_WR_IMEM = 8'h01;
    localparam logic [7:0] OP_WR_DMEM = 8'h02;
    localparam logic [7:0] OP_RD_IMEM = 8'h03;
    localparam logic [7:0] OP_RD_DMEM = 8'h04;
    localparam logic [7:0] OP_RUN     = 8'h05;
    localparam logic [7:0] OP_HALT    = 8'h06;
`ifdef LOADER_ACK_EN
    localparam logic [7:0] STAT_OK    = 8'hA5;
    localparam logic [7:0] STAT_ERR   = 8'hEE;
`endif
    localparam logic [31:0]      ADDR_INC = 32'(ADDR_STEP);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    state_t             state_q, state_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        shift_q, shift_d;
    logic               sel_dmem_q, sel_dmem_d;
    logic               is_rd_q, is_rd_d;
    logic               cpu_enable_q, cpu_enable_d;
    logic               err_q, err_d;
    logic               wen_ext_q, wen_ext_d, wen_ext_2_q, wen_ext_2_d;
    logic               ren_ext_q, ren_ext_d, ren_ext_2_q, ren_ext_2_d;
    logic               tx_valid_q, tx_valid_d;
    logic               rx_ready_q, rx_ready_d;
    logic               busy_q, busy_d;

    logic               rx_fire_s, tx_fire_s, done_s, cmd_err_s;
    logic [CNT_W-1:0]   cnt_shift_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        wdata_d      = wdata_q;
        shift_d      = shift_q;
        sel_dmem_d   = sel_dmem_q;
        is_rd_d      = is_rd_q;
        cpu_enable_d = cpu_enable_q;
        err_d        = err_q;
        done_s       = 1'b0;
        cmd_err_s    = 1'b0;
        rx_fire_s    = rx_valid && rx_ready_q;
        tx_fire_s    = tx_valid_q && tx_ready;
        cnt_shift_s  = (cnt_q << 8) | CNT_W'(rx_data);

        case (state_q)
            ST_IDLE: begin
                if (rx_fire_s) begin
                    case (rx_data)
                        OP_CLR: begin
                            err_d  = 1'b0;
                            done_s = 1'b1;
                        end
                        OP_WR_IMEM, OP_WR_DMEM, OP_RD_IMEM, OP_RD_DMEM: begin
                            if (cpu_enable_q) begin
                                cmd_err_s = 1'b1;
                                done_s    = 1'b1;
                            end else begin
                                sel_dmem_d = (rx_data == OP_WR_DMEM) || (rx_data == OP_RD_DMEM);
                                is_rd_d    = (rx_data == OP_RD_IMEM) || (rx_data == OP_RD_DMEM);
                                bcnt_d     = 2'd0;
                                cnt_d      = '0;
                                state_d    = ST_ADDR;
                            end
                        end
                        OP_RUN: begin
                            cpu_enable_d = 1'b1;
                            done_s       = 1'b1;
                        end
                        OP_HALT: begin
                            cpu_enable_d = 1'b0;
                            done_s       = 1'b1;
                        end
                        default: begin
                            cmd_err_s = 1'b1;
                            done_s    = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (rx_fire_s) begin
                    addr_d = {addr_q[23:0], rx_data};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = ST_CNT;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_CNT: begin
                if (rx_fire_s) begin
                    cnt_d = cnt_shift_s;
                    if (bcnt_q == 2'd1) begin
                        bcnt_d = 2'd0;
                        if (cnt_shift_s == '0) begin
                            done_s = 1'b1;
                        end else if (is_rd_q) begin
                            state_d = ST_RD_REQ;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end else begin
                    state_d = ST_CNT;
                end
            end
            ST_WDATA: begin
                if (rx_fire_s) begin
                    wdata_d = {wdata_q[23:0], rx_data};
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_WRITE: begin
                addr_d = addr_q + ADDR_INC;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    done_s = 1'b1;
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_RD_REQ: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                shift_d = sel_dmem_q ? rdata_ext_2 : rdata_ext;
                bcnt_d  = 2'd0;
                state_d = ST_TX;
            end
            ST_TX: begin
                if (tx_fire_s) begin
                    shift_d = {shift_q[23:0], 8'h00};
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        addr_d = addr_q + ADDR_INC;
                        cnt_d  = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            done_s = 1'b1;
                        end else begin
                            state_d = ST_RD_REQ;
                        end
                    end else begin
                        state_d = ST_TX;
                    end
                end else begin
                    state_d = ST_TX;
                end
            end
            ST_ACK: begin
                if (tx_fire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every finished command funnels through here so the status byte sees the same outcome.
`ifdef LOADER_ACK_EN
        state_d = done_s ? ST_ACK : state_d;
        shift_d = done_s ? {(cmd_err_s ? STAT_ERR : STAT_OK), 24'h000000} : shift_d;
`else
        state_d = done_s ? ST_IDLE : state_d;
`endif
        err_d = cmd_err_s ? 1'b1 : err_d;

        wen_ext_d   = (state_d == ST_WRITE)  && !sel_dmem_d;
        wen_ext_2_d = (state_d == ST_WRITE)  &&  sel_dmem_d;
        ren_ext_d   = (state_d == ST_RD_REQ) && !sel_dmem_d;
        ren_ext_2_d = (state_d == ST_RD_REQ) &&  sel_dmem_d;
        tx_valid_d  = (state_d == ST_TX) || (state_d == ST_ACK);
        rx_ready_d  = (state_d == ST_IDLE) || (state_d == ST_ADDR) ||
                      (state_d == ST_CNT)  || (state_d == ST_WDATA);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            bcnt_q       <= 2'd0;
            addr_q       <= 32'h0000_0000;
            cnt_q        <= '0;
            wdata_q      <= 32'h0000_0000;
            shift_q      <= 32'h0000_0000;
            sel_dmem_q   <= 1'b0;
            is_rd_q      <= 1'b0;
            cpu_enable_q <= 1'b0;
            err_q        <= 1'b0;
            wen_ext_q    <= 1'b0;
            wen_ext_2_q  <= 1'b0;
            ren_ext_q    <= 1'b0;
            ren_ext_2_q  <= 1'b0;
            tx_valid_q   <= 1'b0;
            rx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            wdata_q      <= wdata_d;
            shift_q      <= shift_d;
            sel_dmem_q   <= sel_dmem_d;
            is_rd_q      <= is_rd_d;
            cpu_enable_q <= cpu_enable_d;
            err_q        <= err_d;
            wen_ext_q    <= wen_ext_d;
            wen_ext_2_q  <= wen_ext_2_d;
            ren_ext_q    <= ren_ext_d;
            ren_ext_2_q  <= ren_ext_2_d;
            tx_valid_q   <= tx_valid_d;
            rx_ready_q   <= rx_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_ready    = rx_ready_q;
    assign tx_data     = shift_q[31:24];
    assign tx_valid    = tx_valid_q;
    assign addr_ext    = addr_q;
    assign addr_ext_2  = addr_q;
    assign wdata_ext   = wdata_q;
    assign wdata_ext_2 = wdata_q;
    assign wen_ext     = wen_ext_q;
    assign wen_ext_2   = wen_ext_2_q;
    assign ren_ext     = ren_ext_q;
    assign ren_ext_2   = ren_ext_2_q;
    assign cpu_enable  = cpu_enable_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_ext_loader.sv
// Directed self-checking bench for mem_ext_loader; status-byte checks are active when LOADER_ACK_EN is defined.
module tb_mem_ext_loader;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic [31:0] rdata_ext = 32'h0, rdata_ext_2 = 32'h0;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic        cpu_enable, busy, err;

    int errors = 0;
    int checks = 0;

    mem_ext_loader #(.CNT_W(16), .ADDR_STEP(4)) dut (
        .clk(clk), .arst_n(arst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: one-cycle latency after the ren pulse.
    always @(posedge clk) begin
        if (ren_ext_2) rdata_ext_2 <= (addr_ext_2 == 32'h0000_0020) ? 32'hCAFE_F00D : 32'hDEAD_0000;
        if (ren_ext)   rdata_ext   <= 32'h1122_3344;
    end

    // Bus observers sampled on the falling edge.
    logic [31:0] wen_addr_log[$];
    logic [31:0] wen_data_log[$];
    logic [7:0]  tx_log[$];
    int          wen2_cnt = 0, ren1_cnt = 0, ren2_cnt = 0, hold_viol = 0;
    int          cyc = 0, ren2_cyc = 0, txv_rise_cyc = 0;
    logic [31:0] ren2_addr = 32'h0;
    logic        pend = 1'b0, txv_prev = 1'b0;
    logic [7:0]  pend_data = 8'h00;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wen_ext) begin
            wen_addr_log.push_back(addr_ext);
            wen_data_log.push_back(wdata_ext);
        end
        if (wen_ext_2) wen2_cnt <= wen2_cnt + 1;
        if (ren_ext) ren1_cnt <= ren1_cnt + 1;
        if (ren_ext_2) begin
            ren2_cnt  <= ren2_cnt + 1;
            ren2_addr <= addr_ext_2;
            ren2_cyc  <= cyc;
        end
        if (pend && tx_valid && (tx_data !== pend_data)) hold_viol <= hold_viol + 1;
        pend      <= tx_valid && !tx_ready;
        pend_data <= tx_data;
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (tx_valid && !txv_prev) txv_rise_cyc <= cyc;
        txv_prev <= tx_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!rx_ready) begin
            errors++;
            $display("FAIL rx_timeout: byte %h never accepted (rx_ready=%b, want 1)", b, rx_ready);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
    endtask

    task automatic clear_logs();
        wen_addr_log.delete(); wen_data_log.delete(); tx_log.delete();
        wen2_cnt = 0; ren1_cnt = 0; ren2_cnt = 0; hold_viol = 0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        #12;
        checks++;
        if ({busy, rx_ready, tx_valid, cpu_enable, err, wen_ext, wen_ext_2, ren_ext, ren_ext_2} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000000",
                     {busy, rx_ready, tx_valid, cpu_enable, err, wen_ext, wen_ext_2, ren_ext, ren_ext_2});
        end
        @(posedge clk); #1;
        arst_n = 1'b1;
        idle(2);
        checks++;
        if (rx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: rx_ready=%b busy=%b want 1 0", rx_ready, busy);
        end
        clear_logs();
        send_byte(8'h01); send_word(32'h0000_0010); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_wdata_busy: got %b want 1", busy); end
        @(posedge clk); #1;
        arst_n = 1'b0;
        #2;
        checks++;
        if ({addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, tx_data} !== 136'h0 ||
            {busy, rx_ready, tx_valid, wen_ext, wen_ext_2} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: addr=%h wdata=%h tx=%h ctrl=%b want all 0",
                     addr_ext, wdata_ext, tx_data, {busy, rx_ready, tx_valid, wen_ext, wen_ext_2});
        end
        @(posedge clk); #1;
        arst_n = 1'b1;
        idle(4);
        checks++;
        if (wen_addr_log.size() != 0 || wen2_cnt != 0) begin
            errors++;
            $display("FAIL reset_no_pulse: wen=%0d wen2=%0d want 0 0", wen_addr_log.size(), wen2_cnt);
        end
        send_byte(8'h05); idle(3);
        checks++;
        if (cpu_enable !== 1'b1) begin errors++; $display("FAIL post_reset_run: got %b want 1", cpu_enable); end
        send_byte(8'h06); idle(3);
        checks++;
        if (cpu_enable !== 1'b0) begin errors++; $display("FAIL post_reset_halt: got %b want 0", cpu_enable); end
    endtask

    task automatic test_write();
        clear_logs();
        send_byte(8'h01); send_word(32'h0000_0010); send_byte(8'h00); send_byte(8'h02);
        send_word(32'hDEAD_BEEF); send_word(32'h1234_5678);
        idle(4);
        checks++;
        if (wen_addr_log.size() != 2) begin
            errors++; $display("FAIL wr_count: got %0d want 2", wen_addr_log.size());
        end else begin
            checks++;
            if (wen_addr_log[0] !== 32'h10 || wen_data_log[0] !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL wr_word0: got %h/%h want 00000010/deadbeef", wen_addr_log[0], wen_data_log[0]);
            end
            checks++;
            if (wen_addr_log[1] !== 32'h14 || wen_data_log[1] !== 32'h1234_5678) begin
                errors++; $display("FAIL wr_word1: got %h/%h want 00000014/12345678", wen_addr_log[1], wen_data_log[1]);
            end
        end
        checks++;
        if (wen2_cnt != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL wr_other_mem: wen2=%0d busy=%b want 0 0", wen2_cnt, busy);
        end
    endtask

    task automatic test_read();
        int exp_n;
`ifdef LOADER_ACK_EN
        exp_n = 5;
`else
        exp_n = 4;
`endif
        idle(4);
        clear_logs();
        tx_ready = 1'b0;
        send_byte(8'h04); send_word(32'h0000_0020); send_byte(8'h00); send_byte(8'h01);
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            tx_ready = ~tx_ready;
            if (!busy && tx_log.size() >= exp_n) break;
        end
        tx_ready = 1'b1;
        idle(2);
        checks++;
        if (ren2_cnt != 1 || ren2_addr !== 32'h20 || ren1_cnt != 0) begin
            errors++; $display("FAIL rd_pulse: ren2=%0d addr=%h ren1=%0d want 1 00000020 0", ren2_cnt, ren2_addr, ren1_cnt);
        end
        checks++;
        if (tx_log.size() != exp_n) begin
            errors++; $display("FAIL rd_bytes: got %0d want %0d", tx_log.size(), exp_n);
        end
        if (tx_log.size() >= 4) begin
            checks++;
            if ({tx_log[0], tx_log[1], tx_log[2], tx_log[3]} !== 32'hCAFE_F00D) begin
                errors++; $display("FAIL rd_data: got %h%h%h%h want cafef00d", tx_log[0], tx_log[1], tx_log[2], tx_log[3]);
            end
        end
        checks++;
        if (hold_viol != 0) begin errors++; $display("FAIL rd_hold: got %0d changes want 0", hold_viol); end
        checks++;
        if (txv_rise_cyc - ren2_cyc != 2) begin
            errors++; $display("FAIL rd_latency: got %0d want 2", txv_rise_cyc - ren2_cyc);
        end
    endtask

    task automatic test_cpu_enable();
        clear_logs();
        send_byte(8'h05); idle(3);
        checks++;
        if (cpu_enable !== 1'b1) begin errors++; $display("FAIL run: got %b want 1", cpu_enable); end
        send_byte(8'h02);
`ifndef LOADER_ACK_EN
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL locked_busy: got %b want 0", busy); end
`endif
        idle(3);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL locked_err: got %b want 1", err); end
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        send_byte(8'h01);
        idle(3);
        checks++;
        if (wen2_cnt != 0 || wen_addr_log.size() != 0 || err !== 1'b1 || cpu_enable !== 1'b1) begin
            errors++; $display("FAIL locked_no_write: wen2=%0d wen=%0d err=%b en=%b want 0 0 1 1",
                               wen2_cnt, wen_addr_log.size(), err, cpu_enable);
        end
        send_byte(8'h06); idle(3);
        checks++;
        if (cpu_enable !== 1'b0) begin errors++; $display("FAIL halt: got %b want 0", cpu_enable); end
        send_byte(8'h00); idle(3);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL clr: got %b want 0", err); end
    endtask

    task automatic test_wrap();
        clear_logs();
        send_byte(8'h7F); idle(3);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL bad_opcode: got %b want 1", err); end
        send_byte(8'h01); send_word(32'hFFFF_FFFC); send_byte(8'h00); send_byte(8'h02);
        send_word(32'h1111_1111); send_word(32'h2222_2222);
        idle(4);
        checks++;
        if (wen_addr_log.size() != 2) begin
            errors++; $display("FAIL wrap_count: got %0d want 2", wen_addr_log.size());
        end else begin
            checks++;
            if (wen_addr_log[0] !== 32'hFFFF_FFFC || wen_addr_log[1] !== 32'h0000_0000 ||
                wen_data_log[1] !== 32'h2222_2222) begin
                errors++; $display("FAIL wrap_addr: got %h,%h data1 %h want fffffffc,00000000 22222222",
                                   wen_addr_log[0], wen_addr_log[1], wen_data_log[1]);
            end
        end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
        send_byte(8'h01); send_word(32'h0000_0040); send_byte(8'h00); send_byte(8'h00);
        idle(3);
        checks++;
        if (wen_addr_log.size() != 2 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_count: wen=%0d busy=%b want 2 0", wen_addr_log.size(), busy);
        end
        send_byte(8'h00); idle(3);
    endtask

`ifdef LOADER_ACK_EN
    task automatic test_ack();
        clear_logs();
        tx_ready = 1'b1;
        send_byte(8'h05); idle(4);
        send_byte(8'h7F); idle(4);
        checks++;
        if (tx_log.size() != 2) begin
            errors++; $display("FAIL ack_count: got %0d want 2", tx_log.size());
        end else begin
            checks++;
            if (tx_log[0] !== 8'hA5 || tx_log[1] !== 8'hEE) begin
                errors++; $display("FAIL ack_bytes: got %h %h want a5 ee", tx_log[0], tx_log[1]);
            end
        end
        send_byte(8'h00); idle(4);
        tx_ready = 1'b0;
        send_byte(8'h06); idle(4);
        checks++;
        if (rx_ready !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            errors++; $display("FAIL ack_hold: rx_ready=%b tx_valid=%b tx=%h want 0 1 a5", rx_ready, tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        idle(3);
        checks++;
        if (rx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ack_release: rx_ready=%b busy=%b want 1 0", rx_ready, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_cpu_enable();
        test_wrap();
`ifdef LOADER_ACK_EN
        test_ack();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ext_loader.md
Name: mem_ext_loader

Overview:
- Host-side initiator for the CPU's external memory access ports (instruction memory `*_ext`, data memory `*_ext_2`) and the CPU `enable` input.
- Accepts a byte-oriented command stream over a valid/ready byte interface and assembles big-endian 32-bit words.
- Issues single-cycle write and read pulses to either memory, and streams read-back words out on a byte transmit interface.
- Starts and stops the CPU through `cpu_enable`. Sits between a host link (UART/JTAG bridge) and `cpu`.

Parameters:
- CNT_W, 16: width of the word-count field and the internal word counter.
- ADDR_STEP, 4: byte-address increment applied after each word access.

Ports:
- clk  in  1  system clock.
- arst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  command/payload byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- tx_data  out  8  read-back byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts a byte.
- addr_ext  out  32  instruction-memory external address.
- wen_ext  out  1  instruction-memory write pulse.
- ren_ext  out  1  instruction-memory read pulse.
- wdata_ext  out  32  instruction-memory write word.
- rdata_ext  in  32  instruction-memory read word.
- addr_ext_2  out  32  data-memory external address.
- wen_ext_2  out  1  data-memory write pulse.
- ren_ext_2  out  1  data-memory read pulse.
- wdata_ext_2  out  32  data-memory write word.
- rdata_ext_2  in  32  data-memory read word.
- cpu_enable  out  1  drives cpu enable.
- busy  out  1  FSM not in IDLE.
- err  out  1  sticky protocol error.

Behaviour:
- One clock (clk); reset asynchronous, active-low (arst_n).
- On reset, all outputs are 0:
  - addr/wdata buses 0
  - all wen/ren 0
  - tx_valid 0
  - cpu_enable 0
  - err 0
  - FSM to IDLE; partial word discarded
  - no access pulse is issued as a result of reset.
- Byte handshake:
  - A byte is consumed when rx_valid && rx_ready.
  - rx_ready = 1 only in IDLE, ADDR, CNT, WDATA.
- Command opcodes (first byte, decoded in IDLE):
  - 0x00 CLR: clears err.
  - 0x01 WR_IMEM, 0x02 WR_DMEM, 0x03 RD_IMEM, 0x04 RD_DMEM.
  - 0x05 RUN: cpu_enable <= 1.
  - 0x06 HALT: cpu_enable <= 0.
  - Any other opcode: err <= 1, stay IDLE.
  - Memory opcode while cpu_enable = 1: err <= 1, byte discarded, stay IDLE.
- Memory command framing: opcode, 4 address bytes (MSB first, byte address), 2 count bytes (MSB first, word count N).
  - Count N = 0 returns to IDLE with no access.
- Write path:
  - WDATA collects 4 bytes MSB first (2-bit byte counter).
  - The cycle after the 4th byte is accepted, WRITE drives the selected wen high for exactly one cycle, with addr/wdata stable.
  - Then addr += ADDR_STEP (mod 2^32) and the word counter decrements.
  - Next state: WDATA if words remain, else IDLE.
  - The unselected memory's wen/ren stay 0.
- Read path:
  - RD_REQ: selected ren high one cycle with addr.
  - RD_CAP (next cycle): capture the rdata bus into a 32-bit shift register.
  - TX: tx_valid = 1, tx_data = word[31:24]; tx_data is held until tx_ready, then shifts. 4 bytes per word.
  - After the 4th byte: addr += ADDR_STEP; then RD_REQ if words remain, else IDLE.
- Latency and stalls:
  - Write word: 1 cycle after the last byte.
  - Read: ren to first tx_valid = 2 cycles.
  - Back-pressure on tx stalls the FSM indefinitely with no extra accesses.
- busy = (state != IDLE).
- cpu_enable changes only on RUN/HALT or reset.
- Address counter and word counter wrap silently; no error on wrap.

Optional Feature:
- Macro LOADER_ACK_EN.
- When defined:
  - On return to IDLE after any command, the loader emits one status byte on tx: 0xA5 on success, 0xEE if that command set err. This includes CLR, RUN, HALT, N=0 and rejected opcodes.
  - The status byte follows any read-back data.
  - The FSM adds an ACK state; rx_ready = 0 until the status byte is accepted.
- When undefined: no status bytes; tx carries read-back data only.

Test Plan:
- Reset mid-WDATA, after 2 of 4 bytes of WR_IMEM → no wen_ext pulse; all outputs 0; the next IDLE accepts opcode normally.
- Stream 01 00000010 0002 DEADBEEF 12345678 → wen_ext pulses twice: addr 0x10 / data 0xDEADBEEF, then addr 0x14 / data 0x12345678; wen_ext_2 never asserts.
- Preload DMEM[0x20] = 0xCAFEF00D; send 04 00000020 0001 with tx_ready toggling 1/0 → ren_ext_2 single pulse at addr 0x20; tx bytes CA FE F0 0D, each held stable while tx_ready = 0.
- Send 05 then 02 00000000 0001 → cpu_enable = 1; second command sets err = 1, no wen_ext_2, busy stays 0; 06 → cpu_enable = 0; 00 → err = 0.
- Send opcode 0x7F, then 01 FFFFFFFC 0002 with two words → err = 1; writes go to 0xFFFFFFFC then 0x00000000.
- LOADER_ACK_EN build: 05 → tx 0xA5; 0x7F → tx 0xEE; rx_ready = 0 until each status byte is taken.
